// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and deglitches the pins, deserialises
// 11-bit odd-parity frames and reports each byte or fault with a one-cycle strobe.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       error,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_FRAMING = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    logic                  clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic                  dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
    logic [FILTER_LEN-1:0] hist_q, hist_d;
    logic                  filt_q, filt_d, filt_prev_q, filt_prev_d;
    logic                  fall;

    state_e                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_q, par_d, par_ok_q, par_ok_d;
    logic [CNT_W-1:0]      to_cnt_q, to_cnt_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d, error_q, error_d;
    logic [1:0]            err_code_q, err_code_d;

    // The filter looks at the history including the sample being shifted in this cycle,
    // so a pin edge reaches the FSM 2 + FILTER_LEN + 1 cycles later.
    always_comb begin
        clk_meta_d  = ps2_clk;
        clk_sync_d  = clk_meta_q;
        dat_meta_d  = ps2_data;
        dat_sync_d  = dat_meta_q;
        hist_d      = {hist_q[FILTER_LEN-2:0], clk_sync_q};
        filt_prev_d = filt_q;
        filt_d      = filt_q;
        if (hist_d == '0) begin
            filt_d = 1'b0;
        end else if (&hist_d) begin
            filt_d = 1'b1;
        end
        fall = filt_prev_q & ~filt_q;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        par_ok_d   = par_ok_q;
        to_cnt_d   = to_cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code_q;

        if (state_q == IDLE) begin
            to_cnt_d = '0;
            if (fall && !dat_sync_q) begin
                state_d   = DATA;
                bit_cnt_d = '0;
                par_d     = 1'b0;
            end
        end else if (fall) begin
            // A falling edge always beats a timeout landing in the same cycle.
            to_cnt_d = '0;
            unique case (state_q)
                DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    par_d     = par_q ^ dat_sync_q;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_ok_d = par_q ^ dat_sync_q;
                    state_d  = STOP;
                end
                default: begin
                    state_d = IDLE;
                    if (!dat_sync_q) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_FRAMING;
                    end else if (!par_ok_q) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_PARITY;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            endcase
        end else if (to_cnt_q == TO_LAST) begin
            state_d    = IDLE;
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling its pre-edge input,
    // which is what makes the two-stage synchronisers actually two stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            dat_meta_q  <= 1'b1;
            dat_sync_q  <= 1'b1;
            hist_q      <= '1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            par_ok_q    <= 1'b0;
            to_cnt_q    <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= '0;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            dat_meta_q  <= dat_meta_d;
            dat_sync_q  <= dat_sync_d;
            hist_q      <= hist_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            par_ok_q    <= par_ok_d;
            to_cnt_q    <= to_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    assign data     = data_q;
    assign valid    = valid_q;
    assign error    = error_q;
    assign err_code = err_code_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: PS/2 frames are bit-banged on the pins with a short
// bit period and timeout so the whole run stays small; strobes are tallied by a monitor.
module tb_ps2_rx;

    localparam int F = 8;      // FILTER_LEN
    localparam int T = 400;    // TIMEOUT_CYCLES
    localparam int H = 50;     // half PS/2 bit period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data;
    logic       valid, error, busy;
    logic [1:0] err_code;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_fall = 0;

    int n_valid = 0, n_error = 0, n_both = 0, n_long = 0, n_busy = 0, n_busy_strobe = 0;
    int err_cyc = 0;
    logic prev_valid = 1'b0, prev_error = 1'b0;

    ps2_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data(data), .valid(valid), .error(error), .err_code(err_code), .busy(busy)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            n_valid++;
            if (busy !== 1'b0) n_busy_strobe++;
        end
        if (error === 1'b1) begin
            n_error++;
            err_cyc = cyc;
        end
        if (valid === 1'b1 && error === 1'b1) n_both++;
        if ((valid === 1'b1 && prev_valid === 1'b1) || (error === 1'b1 && prev_error === 1'b1)) n_long++;
        if (busy === 1'b1) n_busy++;
        prev_valid = valid;
        prev_error = error;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] mk(input logic [7:0] b, input logic par, input logic stop);
        return {stop, par, b, 1'b0};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Device-style timing: data changes mid-high, clk low for H, high for H.
    task automatic send_bits(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            cycles(H / 2);
            last_fall = cyc;
            ps2_clk = 1'b0;
            cycles(H);
            ps2_clk = 1'b1;
            cycles(H / 2);
        end
        ps2_data = 1'b1;
    endtask

    task automatic test_reset();
        cycles(3);
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error); end
        total++; if (err_code !== 2'b00) begin bad++; $display("FAIL reset_err_code: got %b want 00", err_code); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        cycles(5);
    endtask

    task automatic test_glitch();
        int v0, e0, b0;
        v0 = n_valid; e0 = n_error; b0 = n_busy;
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        cycles(F - 2);
        ps2_clk = 1'b1;
        cycles(40);
        ps2_data = 1'b1;
        total++; if (n_busy - b0 != 0) begin bad++; $display("FAIL glitch_busy: busy cycles %0d want 0", n_busy - b0); end
        total++; if (n_valid - v0 != 0) begin bad++; $display("FAIL glitch_valid: pulses %0d want 0", n_valid - v0); end
        total++; if (n_error - e0 != 0) begin bad++; $display("FAIL glitch_error: pulses %0d want 0", n_error - e0); end
    endtask

    task automatic test_good(input logic [7:0] b, input logic par);
        int v0, e0;
        v0 = n_valid; e0 = n_error;
        send_bits(mk(b, par, 1'b1), 11);
        cycles(10);
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL good_valid_%h: pulses %0d want 1", b, n_valid - v0); end
        total++; if (n_error - e0 != 0) begin bad++; $display("FAIL good_error_%h: pulses %0d want 0", b, n_error - e0); end
        total++; if (data !== b) begin bad++; $display("FAIL good_data_%h: got %h want %h", b, data, b); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL good_busy_%h: got %b want 0", b, busy); end
    endtask

    task automatic test_parity();
        int v0, e0;
        v0 = n_valid; e0 = n_error;
        // 0x5A has four ones, so parity bit 0 makes the nine-bit XOR even.
        send_bits(mk(8'h5A, 1'b0, 1'b1), 11);
        cycles(10);
        total++; if (n_error - e0 != 1) begin bad++; $display("FAIL parity_error: pulses %0d want 1", n_error - e0); end
        total++; if (err_code !== 2'b01) begin bad++; $display("FAIL parity_code: got %b want 01", err_code); end
        total++; if (n_valid - v0 != 0) begin bad++; $display("FAIL parity_valid: pulses %0d want 0", n_valid - v0); end
        total++; if (data !== 8'h1C) begin bad++; $display("FAIL parity_data: got %h want 1c", data); end
    endtask

    task automatic test_framing();
        int v0, e0;
        v0 = n_valid; e0 = n_error;
        send_bits(mk(8'h29, 1'b0, 1'b0), 11);
        cycles(10);
        total++; if (n_error - e0 != 1) begin bad++; $display("FAIL framing_error: pulses %0d want 1", n_error - e0); end
        total++; if (err_code !== 2'b10) begin bad++; $display("FAIL framing_code: got %b want 10", err_code); end
        total++; if (n_valid - v0 != 0) begin bad++; $display("FAIL framing_valid: pulses %0d want 0", n_valid - v0); end
        total++; if (data !== 8'hF0) begin bad++; $display("FAIL framing_data: got %h want f0", data); end
        test_good(8'h29, 1'b0);
    endtask

    task automatic test_timeout();
        int v0, e0;
        v0 = n_valid; e0 = n_error;
        send_bits(mk(8'h12, 1'b1, 1'b1), 4);
        cycles(T + 50);
        total++; if (n_error - e0 != 1) begin bad++; $display("FAIL timeout_error: pulses %0d want 1", n_error - e0); end
        total++; if (err_code !== 2'b11) begin bad++; $display("FAIL timeout_code: got %b want 11", err_code); end
        total++; if (err_cyc - last_fall != 3 + F + T) begin
            bad++; $display("FAIL timeout_delay: got %0d want %0d cycles after pin edge", err_cyc - last_fall, 3 + F + T);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b want 0", busy); end
        total++; if (n_valid - v0 != 0) begin bad++; $display("FAIL timeout_valid: pulses %0d want 0", n_valid - v0); end
        test_good(8'h12, 1'b1);
    endtask

    task automatic test_back_to_back();
        int v0, e0;
        v0 = n_valid; e0 = n_error;
        send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
        send_bits(mk(8'h29, 1'b0, 1'b1), 11);
        cycles(10);
        total++; if (n_valid - v0 != 2) begin bad++; $display("FAIL b2b_valid: pulses %0d want 2", n_valid - v0); end
        total++; if (n_error - e0 != 0) begin bad++; $display("FAIL b2b_error: pulses %0d want 0", n_error - e0); end
        total++; if (data !== 8'h29) begin bad++; $display("FAIL b2b_data: got %h want 29", data); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0;
        v0 = n_valid; e0 = n_error;
        send_bits(mk(8'hAA, 1'b1, 1'b1), 5);
        cycles(20);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        cycles(3);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL midrst_data: got %h want 00", data); end
        reset = 1'b0;
        cycles(5);
        send_bits(mk(8'h76, 1'b0, 1'b1), 11);
        cycles(10);
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL midrst_valid: pulses %0d want 1", n_valid - v0); end
        total++; if (n_error - e0 != 0) begin bad++; $display("FAIL midrst_error: pulses %0d want 0", n_error - e0); end
        total++; if (data !== 8'h76) begin bad++; $display("FAIL midrst_data_after: got %h want 76", data); end
    endtask

    task automatic test_strobe_shape();
        total++; if (n_both != 0) begin bad++; $display("FAIL strobe_exclusive: overlaps %0d want 0", n_both); end
        total++; if (n_long != 0) begin bad++; $display("FAIL strobe_width: long pulses %0d want 0", n_long); end
        total++; if (n_busy_strobe != 0) begin bad++; $display("FAIL strobe_busy: busy with valid %0d want 0", n_busy_strobe); end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_good(8'h1C, 1'b0);
        test_parity();
        test_good(8'hF0, 1'b1);
        test_framing();
        test_timeout();
        test_back_to_back();
        test_reset_mid_frame();
        test_strobe_shape();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
